adc_sample_averager: RTL and testbench
======================================

Name: adc_sample_averager

Overview:
- Stage directly downstream of the digital ADC capture path. Consumes its single-cycle valid pulse and WIDTH-bit conversion value.
- Averages each block of 2^LOG2_N consecutive conversions into one result.
- Presents each result on a valid/ready handshake to the next consumer.
- Counts results lost to output backpressure.

Parameters:
- WIDTH, 8, bit width of input conversion values and output average
- LOG2_N, 2, log2 of samples per average (0 = pass-through with 1-cycle latency)
- OVR_WIDTH, 8, width of saturating overrun counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low (0 = reset)
- en  input  1  sample accept enable; when 0, input pulses are ignored
- clr  input  1  synchronous clear of partial accumulation (not of output/overrun)
- in_valid  input  1  single-cycle pulse from ADC capture: in_data holds a new conversion
- in_data  input  WIDTH  conversion value
- out_valid  output  1  out_data holds an unconsumed average
- out_ready  input  1  consumer accepts out_data this cycle when out_valid=1
- out_data  output  WIDTH  averaged result
- fill_count  output  max(LOG2_N,1)  samples accumulated in the current block
- overrun_count  output  OVR_WIDTH  results dropped because the output was full; saturates

Behaviour:
- Reset (rst=0 at a clock edge): accumulator, fill_count, out_valid, out_data and overrun_count all go to 0. FSM enters EMPTY. The reset overrides all other inputs in that cycle.
- Accept: a sample is taken when en=1, in_valid=1, clr=0. There is no upstream backpressure: an input pulse is either accepted or ignored.
- Accumulator is WIDTH+LOG2_N bits and cannot overflow; sum of 2^LOG2_N max values fits.
- On an accepted sample with fill_count < N-1: acc <= acc + in_data, fill_count <= fill_count + 1.
- On an accepted sample with fill_count == N-1 (block complete):
  - result = (acc + in_data) >> LOG2_N, truncating with no rounding.
  - acc <= 0 and fill_count <= 0 in the same cycle, so the next block starts cleanly.
- clr=1: acc <= 0, fill_count <= 0. An in_valid in the same cycle is discarded. out_valid, out_data and overrun_count are unaffected.
- en=0: partial accumulation is held unchanged, not cleared.
- FSM (output side), states EMPTY and FULL:
  - EMPTY: out_valid=0. A block completing moves to FULL, with out_data <= result and out_valid=1 on the next cycle (latency 1 clock from the Nth accepted pulse).
  - FULL: out_valid=1; out_data is held stable.
    - out_ready=1, no completion: go to EMPTY.
    - out_ready=1 and completion in the same cycle: load the new result and stay FULL (out_valid stays 1, no bubble, no overrun).
    - out_ready=0 and completion: the new result is dropped, out_data is kept, and overrun_count increments, saturating at 2^OVR_WIDTH-1.
- out_ready is ignored in EMPTY.
- LOG2_N=0: every accepted sample completes a block. fill_count is constant 0 and out_data = in_data one cycle later.
- Reset asserted mid-block: the partial sum is discarded and the first post-reset accepted sample begins a new block.
- No combinational path from in_* or out_ready to any output; all outputs are registered.

Test Plan:
- WIDTH=8, LOG2_N=2, out_ready=1; pulses 10,20,30,40 on separated cycles -> out_valid=1 for exactly one cycle, beginning 1 clock after the 40 pulse, with out_data=25; fill_count sequence 1,2,3,0.
- Pulses 255,255,255,255 -> out_data=255, no wrap. Pulses 1,1,1,2 -> out_data=1 (truncation).
- out_ready=0; feed 8 samples of value 8, then 8 samples of value 100 -> out_data stays 8, overrun_count=3. Raising out_ready then gives a one-cycle handshake and out_valid=0. OVR_WIDTH=2 with 5 drops -> overrun_count=3 (saturated).
- FULL state, out_ready=1 in the same cycle a block completes with samples 4,4,4,4 -> out_valid stays 1, out_data becomes 4 next cycle, overrun_count unchanged.
- Feed 7,7 then assert clr (with a simultaneous in_valid of 99), then 2,2,2,2 -> out_data=2; the 99 is not counted.
- Feed 7,7 with en=0 pulses interleaved (value 200) -> ignored, fill_count=2. Drive rst=0 for one cycle -> all outputs 0; then 4,8,12,16 -> out_data=10.

Source files
------------

// File: rtl/adc_sample_averager_if.sv
// adc_sample_averager_if
// Groups the sample input stream and the averaged-result handshake that pass
// between the ADC capture path, the averager and the downstream consumer.
//   in_valid  : single-cycle pulse, in_data holds a new conversion
//   in_data   : WIDTH-bit conversion value
//   out_valid : out_data holds an unconsumed average
//   out_ready : consumer takes out_data this cycle when out_valid=1
//   out_data  : WIDTH-bit averaged result
// Modports:
//   master : environment side (drives samples and ready, observes results)
//   slave  : averager side (consumes samples and ready, drives results)
interface adc_sample_averager_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/adc_sample_averager.sv
// adc_sample_averager
// Averages each block of 2^LOG2_N accepted ADC conversions into one result and
// offers it on a valid/ready handshake. Results that complete while the output
// slot is still held by the consumer are dropped and counted.
// Ports:
//   clk           : system clock, rising edge
//   rst           : synchronous active-low reset
//   en            : sample accept enable (partial sum held while 0)
//   clr           : clears the partial accumulation only
//   bus           : sample input stream and result handshake (slave side)
//   fill_count    : samples accumulated in the current block
//   overrun_count : saturating count of dropped results
module adc_sample_averager #(
    parameter int WIDTH     = 8,
    parameter int LOG2_N    = 2,
    parameter int OVR_WIDTH = 8,
    localparam int FILL_W   = (LOG2_N > 0) ? LOG2_N : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    adc_sample_averager_if.slave   bus,
    output logic [FILL_W-1:0]      fill_count,
    output logic [OVR_WIDTH-1:0]   overrun_count
);

    localparam int ACC_W = WIDTH + LOG2_N;
    localparam int N     = 1 << LOG2_N;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] shifted;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] out_data_q;
    logic             accept;
    logic             complete;
    logic             load;
    logic             drop;

    // clr wins over a coincident pulse, so a cleared cycle never accepts.
    assign accept   = en && bus.in_valid && !clr;
    // With LOG2_N=0 fill_count never leaves 0, so every accepted sample completes.
    assign complete = accept && (fill_count == FILL_W'(N - 1));
    assign sum      = acc + ACC_W'(bus.in_data);
    assign shifted  = sum >> LOG2_N;
    assign result   = shifted[WIDTH-1:0];

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = out_data_q;

    // Output slot control: a completion with the slot being drained in the
    // same cycle reloads it directly, so there is no bubble and no overrun.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                if (complete) begin
                    if (bus.out_ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= EMPTY;
            acc           <= '0;
            fill_count    <= '0;
            out_data_q    <= '0;
            overrun_count <= '0;
        end else begin
            state_q <= state_d;

            if (clr || complete) begin
                acc        <= '0;
                fill_count <= '0;
            end else if (accept) begin
                acc        <= sum;
                fill_count <= fill_count + FILL_W'(1);
            end

            if (load) begin
                out_data_q <= result;
            end

            if (drop && (overrun_count != {OVR_WIDTH{1'b1}})) begin
                overrun_count <= overrun_count + OVR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// tb_adc_sample_averager
// Drives three averager configurations from one shared stimulus stream:
//   u0 : LOG2_N=2, OVR_WIDTH=8
//   u1 : LOG2_N=2, OVR_WIDTH=2 (overrun saturation)
//   u2 : LOG2_N=0 (pass-through)
// A behavioural model (running sum / sample count / output slot) predicts every
// output of each instance after every clock.
module tb_adc_sample_averager;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    int l2n  [3] = '{2, 2, 0};
    int omax [3] = '{255, 3, 255};
    int m_sum   [3];
    int m_cnt   [3];
    int m_valid [3];
    int m_data  [3];
    int m_ovr   [3];

    always #5 clk = ~clk;

    adc_sample_averager_if #(.WIDTH(8)) if0 ();
    adc_sample_averager_if #(.WIDTH(8)) if1 ();
    adc_sample_averager_if #(.WIDTH(8)) if2 ();

    assign if0.in_valid  = in_valid;
    assign if0.in_data   = in_data;
    assign if0.out_ready = out_ready;
    assign if1.in_valid  = in_valid;
    assign if1.in_data   = in_data;
    assign if1.out_ready = out_ready;
    assign if2.in_valid  = in_valid;
    assign if2.in_data   = in_data;
    assign if2.out_ready = out_ready;

    logic [1:0] fill0;
    logic [1:0] fill1;
    logic [0:0] fill2;
    logic [7:0] ovr0;
    logic [1:0] ovr1;
    logic [7:0] ovr2;

    adc_sample_averager #(.WIDTH(8), .LOG2_N(2), .OVR_WIDTH(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .bus(if0.slave),
        .fill_count(fill0), .overrun_count(ovr0)
    );

    adc_sample_averager #(.WIDTH(8), .LOG2_N(2), .OVR_WIDTH(2)) u1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .bus(if1.slave),
        .fill_count(fill1), .overrun_count(ovr1)
    );

    adc_sample_averager #(.WIDTH(8), .LOG2_N(0), .OVR_WIDTH(8)) u2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .bus(if2.slave),
        .fill_count(fill2), .overrun_count(ovr2)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock of the reference behaviour for instance i, from the inputs
    // that were present at the edge.
    task automatic modelStep(input int i);
        int n;
        int res;
        bit done;
        n    = 1 << l2n[i];
        res  = 0;
        done = 1'b0;
        if (!rst) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_valid[i] = 0; m_data[i] = 0; m_ovr[i] = 0;
        end else begin
            if (clr) begin
                m_sum[i] = 0; m_cnt[i] = 0;
            end else if (en && in_valid) begin
                m_sum[i] += int'(in_data);
                m_cnt[i] += 1;
                if (m_cnt[i] == n) begin
                    res  = m_sum[i] / n;
                    done = 1'b1;
                    m_sum[i] = 0; m_cnt[i] = 0;
                end
            end
            if (m_valid[i] != 0) begin
                if (done) begin
                    if (out_ready) m_data[i] = res;
                    else if (m_ovr[i] < omax[i]) m_ovr[i] += 1;
                end else if (out_ready) begin
                    m_valid[i] = 0;
                end
            end else if (done) begin
                m_valid[i] = 1;
                m_data[i]  = res;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("u0.out_valid",     int'(if0.out_valid), m_valid[0]);
        checkOutput("u0.out_data",      int'(if0.out_data),  m_data[0]);
        checkOutput("u0.fill_count",    int'(fill0),         m_cnt[0]);
        checkOutput("u0.overrun_count", int'(ovr0),          m_ovr[0]);
        checkOutput("u1.out_valid",     int'(if1.out_valid), m_valid[1]);
        checkOutput("u1.out_data",      int'(if1.out_data),  m_data[1]);
        checkOutput("u1.fill_count",    int'(fill1),         m_cnt[1]);
        checkOutput("u1.overrun_count", int'(ovr1),          m_ovr[1]);
        checkOutput("u2.out_valid",     int'(if2.out_valid), m_valid[2]);
        checkOutput("u2.out_data",      int'(if2.out_data),  m_data[2]);
        checkOutput("u2.fill_count",    int'(fill2),         m_cnt[2]);
        checkOutput("u2.overrun_count", int'(ovr2),          m_ovr[2]);
    endtask

    // Holds the given inputs across one rising edge, advances the model on
    // that edge and compares all outputs 1 time unit later.
    task automatic applyStimulus(input logic r, input logic e, input logic c,
                                 input logic v, input logic [7:0] d, input logic rdy);
        rst = r; en = e; clr = c; in_valid = v; in_data = d; out_ready = rdy;
        @(posedge clk);
        for (int i = 0; i < 3; i++) modelStep(i);
        #1;
        checkAll();
    endtask

    task automatic pulse(input logic [7:0] d, input logic rdy);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, d, rdy);
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, rdy);
    endtask

    initial begin
        logic [7:0] vals [4];

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'd77, 1'b1);
        checkOutput("reset.out_valid", int'(if0.out_valid), 0);
        checkOutput("reset.overrun",   int'(ovr0), 0);

        // Basic average with separated pulses.
        vals = '{8'd10, 8'd20, 8'd30, 8'd40};
        for (int k = 0; k < 4; k++) begin
            pulse(vals[k], 1'b1);
            if (k < 3) begin
                checkOutput("avg25.fill", int'(fill0), k + 1);
                idle(1'b1);
            end
        end
        checkOutput("avg25.valid", int'(if0.out_valid), 1);
        checkOutput("avg25.data",  int'(if0.out_data), 25);
        checkOutput("avg25.fill0", int'(fill0), 0);
        idle(1'b1);
        checkOutput("avg25.one_cycle", int'(if0.out_valid), 0);

        for (int k = 0; k < 4; k++) pulse(8'd255, 1'b1);
        checkOutput("max255.data", int'(if0.out_data), 255);
        vals = '{8'd1, 8'd1, 8'd1, 8'd2};
        for (int k = 0; k < 4; k++) pulse(vals[k], 1'b1);
        checkOutput("trunc.data", int'(if0.out_data), 1);
        idle(1'b1);

        // Backpressure: first result held, later ones dropped.
        for (int k = 0; k < 8; k++) pulse(8'd8, 1'b0);
        for (int k = 0; k < 8; k++) pulse(8'd100, 1'b0);
        checkOutput("ovr.data_held", int'(if0.out_data), 8);
        checkOutput("ovr.count3",    int'(ovr0), 3);
        for (int k = 0; k < 8; k++) pulse(8'd50, 1'b0);
        checkOutput("ovr.sat2bit", int'(ovr1), 3);
        checkOutput("ovr.count5",  int'(ovr0), 5);
        idle(1'b1);
        checkOutput("ovr.drained", int'(if0.out_valid), 0);
        idle(1'b1);

        // Drain and completion in the same cycle keep the slot full.
        for (int k = 0; k < 4; k++) pulse(8'd9, 1'b0);
        for (int k = 0; k < 3; k++) pulse(8'd4, 1'b0);
        pulse(8'd4, 1'b1);
        checkOutput("nobubble.valid", int'(if0.out_valid), 1);
        checkOutput("nobubble.data",  int'(if0.out_data), 4);
        checkOutput("nobubble.ovr",   int'(ovr0), 5);
        idle(1'b1);

        // clr discards the partial sum and a coincident pulse.
        pulse(8'd7, 1'b1);
        pulse(8'd7, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'd99, 1'b1);
        checkOutput("clr.fill", int'(fill0), 0);
        for (int k = 0; k < 4; k++) pulse(8'd2, 1'b1);
        checkOutput("clr.data", int'(if0.out_data), 2);

        // en=0 holds the partial sum; reset discards it.
        pulse(8'd7, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd200, 1'b1);
        pulse(8'd7, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd200, 1'b1);
        checkOutput("en0.fill", int'(fill0), 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'd55, 1'b1);
        checkOutput("rst.fill",  int'(fill0), 0);
        checkOutput("rst.ovr",   int'(ovr0), 0);
        checkOutput("rst.data",  int'(if0.out_data), 0);
        vals = '{8'd4, 8'd8, 8'd12, 8'd16};
        for (int k = 0; k < 4; k++) pulse(vals[k], 1'b1);
        checkOutput("postrst.data", int'(if0.out_data), 10);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            applyStimulus(logic'(($urandom % 100) != 0),
                          logic'(($urandom % 8) != 0),
                          logic'(($urandom % 16) == 0),
                          logic'($urandom % 2),
                          8'($urandom),
                          logic'(($urandom % 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
